dp_tap_ctrl: RTL and testbench
==============================

DP_TAP_CTRL -- requirements
Module: dp_tap_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the shift-cycle counter.
REQ-002 SHALL have ports as follows (port name, direction, width, meaning).
- iclk  in  1  sole system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- tck_en  in  1  one-iclk strobe marking a TCK rising edge; FSM advances only when high.
- tms  in  1  JTAG test-mode select, sampled when tck_en=1.
- state  out  4  current TAP state code per REQ-006.
- shift_ir  out  1  IR cell mux select: serial path.
- clk_ir  out  1  IR cell capture/shift enable.
- update_ir  out  1  IR cell parallel update strobe.
- shift_dr  out  1  DR serial path select.
- clk_dr  out  1  DR capture/shift enable.
- update_dr  out  1  DR parallel update strobe.
- ir_resetn  out  1  active-low reset for IR cells.
- tdo_en  out  1  TDO driver enable.
- sel_ir  out  1  TDO source select: IR chain (1) or DR chain (0).
- shift_cnt  out  CNT_W  number of shift cycles in the current/last Shift-xR visit.

Function
REQ-003 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing exactly once per iclk cycle with tck_en=1 and holding otherwise.
REQ-004 SHALL use these transitions, written as state: tms=0 -> next / tms=1 -> next.
- TLR: RTI / TLR
- RTI: RTI / SELDR
- SELDR: CAPDR / SELIR
- CAPDR: SHDR / EX1DR
- SHDR: SHDR / EX1DR
- EX1DR: PADR / UPDR
- PADR: PADR / EX2DR
- EX2DR: SHDR / UPDR
- UPDR: RTI / SELDR
- SELIR: CAPIR / TLR
- The IR branch mirrors the DR branch.
REQ-005 Five consecutive tck_en strobes with tms=1 SHALL reach TLR from any state.
REQ-006 SHALL use these state codes: TLR=F, RTI=C, SELDR=7, CAPDR=6, SHDR=2, EX1DR=1, PADR=3, EX2DR=0, UPDR=5, SELIR=4, CAPIR=E, SHIR=A, EX1IR=9, PAIR=B, EX2IR=8, UPIR=D.
REQ-007 shift_ir SHALL equal (state==SHIR), combinational from the state register.
REQ-008 clk_ir SHALL equal tck_en AND (state==CAPIR or SHIR), so the capture or shift happens on the same edge that leaves the state.
REQ-009 update_ir SHALL equal tck_en AND (state==UPIR).
REQ-010 shift_dr, clk_dr and update_dr SHALL follow the same rules for SHDR, CAPDR and UPDR.
REQ-011 ir_resetn SHALL be 0 while state==TLR and 1 otherwise.
REQ-012 tdo_en SHALL be registered.
- It is 1 in the cycle after the FSM enters SHIR or SHDR.
- It clears on the exit edge of that state.
REQ-013 sel_ir SHALL be registered: set on entry to SELIR, cleared on entry to SELDR or TLR.
REQ-014 shift_cnt SHALL clear to 0 on entry to CAPIR or CAPDR.
- It increments on every tck_en in SHIR or SHDR.
- It saturates at all-ones with no wrap.
- It holds through Pause/Exit states so a resumed shift continues the count.
REQ-015 While tck_en=0, all strobe outputs (clk_*, update_*) SHALL be 0; level outputs SHALL hold.
REQ-016 When tck_en and reset are asserted together, reset SHALL win.
REQ-017 At most one of clk_ir, clk_dr, update_ir, update_dr SHALL be high in any cycle.

Reset
REQ-018 reset=1 SHALL force, asynchronously, state=TLR, tdo_en=0, sel_ir=0 and shift_cnt=0.
- The combinational outputs follow: ir_resetn=0, all strobes 0.
REQ-019 Reset asserted mid-shift SHALL abandon the shift with no update_* pulse, and the FSM resumes from TLR after release.

Structure
REQ-020 State enum (4-bit, codes per REQ-006) SHALL live in shared package dp_tap_pkg, together with localparam TAP_STATES=16.
REQ-021 SHALL contain one sub-module, dp_tap_fsm (state register and next-state logic only).
- Output decode, tdo_en, sel_ir and shift_cnt stay in dp_tap_ctrl.

Verification
REQ-022 The bench SHALL cover these directed scenarios (stimulus -> required response).
- Reset pulse, then tms=1 x5 strobes -> state=F throughout, ir_resetn=0.
- tms sequence 0,1,1,0,0 from TLR -> state CAPIR (E) reached, then clk_ir=1 with shift_ir=0 on the next strobe, then state=SHIR (A).
- In SHIR, 6 strobes tms=0, then tms=1,1 -> shift_cnt=7, exactly one update_ir pulse, state=UPIR then D.
- DR shift of 4 bits with Pause: SHDR x2, EX1DR, PADR x3, EX2DR, SHDR x2 -> shift_cnt=4, no update_dr during pause, tdo_en=0 in PADR.
- tck_en held 0 for 10 cycles with tms toggling -> state and all outputs unchanged, strobes 0.
- Reset asserted while in SHDR with tck_en=1 -> next cycle state=F, shift_cnt=0, no update_dr ever pulses.

Source files
------------

// File: rtl/dp_tap_pkg.sv
// dp_tap_pkg: shared definitions for the JTAG TAP controller.
//   tap_state_e : 4-bit TAP state encoding (IEEE 1149.1 codes)
//   TAP_STATES  : number of TAP states
//   is_shift()  : true for Shift-IR / Shift-DR
package dp_tap_pkg;

  localparam int TAP_STATES = 16;

  typedef enum logic [3:0] {
    EX2DR = 4'h0,
    EX1DR = 4'h1,
    SHDR  = 4'h2,
    PADR  = 4'h3,
    SELIR = 4'h4,
    UPDR  = 4'h5,
    CAPDR = 4'h6,
    SELDR = 4'h7,
    EX2IR = 4'h8,
    EX1IR = 4'h9,
    SHIR  = 4'hA,
    PAIR  = 4'hB,
    RTI   = 4'hC,
    UPIR  = 4'hD,
    CAPIR = 4'hE,
    TLR   = 4'hF
  } tap_state_e;

  function automatic logic is_shift(input tap_state_e s);
    return (s == SHIR) || (s == SHDR);
  endfunction

endpackage

// File: rtl/dp_tap_fsm.sv
// dp_tap_fsm: TAP state register and next-state logic.
//   clk_i        : system clock
//   rst_i        : asynchronous active-high reset (forces TLR)
//   tck_en_i     : TCK rising-edge strobe; state advances only when high
//   tms_i        : test-mode select
//   state_o      : current state register
//   state_next_o : state that will be loaded on the next clock edge
module dp_tap_fsm
  import dp_tap_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tck_en_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output tap_state_e state_next_o
);

  tap_state_e state_q;
  tap_state_e state_d;

  // Next-state decode; holds when no TCK strobe is present.
  always_comb begin
    state_d = state_q;
    if (tck_en_i) begin
      case (state_q)
        TLR:     state_d = tms_i ? TLR   : RTI;
        RTI:     state_d = tms_i ? SELDR : RTI;
        SELDR:   state_d = tms_i ? SELIR : CAPDR;
        CAPDR:   state_d = tms_i ? EX1DR : SHDR;
        SHDR:    state_d = tms_i ? EX1DR : SHDR;
        EX1DR:   state_d = tms_i ? UPDR  : PADR;
        PADR:    state_d = tms_i ? EX2DR : PADR;
        EX2DR:   state_d = tms_i ? UPDR  : SHDR;
        UPDR:    state_d = tms_i ? SELDR : RTI;
        SELIR:   state_d = tms_i ? TLR   : CAPIR;
        CAPIR:   state_d = tms_i ? EX1IR : SHIR;
        SHIR:    state_d = tms_i ? EX1IR : SHIR;
        EX1IR:   state_d = tms_i ? UPIR  : PAIR;
        PAIR:    state_d = tms_i ? EX2IR : PAIR;
        EX2IR:   state_d = tms_i ? UPIR  : SHIR;
        UPIR:    state_d = tms_i ? SELDR : RTI;
        default: state_d = TLR;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o      = state_q;
  assign state_next_o = state_d;

endmodule

// File: rtl/dp_tap_ctrl.sv
// dp_tap_ctrl: JTAG TAP controller running in the iclk domain.
//   iclk       : system clock          reset     : async active-high reset
//   tck_en     : TCK rising-edge strobe tms      : test-mode select
//   state      : current TAP state code
//   shift_ir/shift_dr   : serial path selects (levels)
//   clk_ir/clk_dr       : capture/shift enables (strobes)
//   update_ir/update_dr : parallel update strobes
//   ir_resetn  : active-low IR reset (low in TLR)
//   tdo_en     : registered TDO driver enable
//   sel_ir     : registered TDO source select (1 = IR chain)
//   shift_cnt  : shift cycles counted in the current/last Shift-xR visit
module dp_tap_ctrl
  import dp_tap_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             iclk,
  input  logic             reset,
  input  logic             tck_en,
  input  logic             tms,
  output logic [3:0]       state,
  output logic             shift_ir,
  output logic             clk_ir,
  output logic             update_ir,
  output logic             shift_dr,
  output logic             clk_dr,
  output logic             update_dr,
  output logic             ir_resetn,
  output logic             tdo_en,
  output logic             sel_ir,
  output logic [CNT_W-1:0] shift_cnt
);

  tap_state_e       state_cur;
  tap_state_e       state_nxt;
  logic             tdo_en_q,    tdo_en_d;
  logic             sel_ir_q,    sel_ir_d;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;

  dp_tap_fsm u_fsm (
    .clk_i        (iclk),
    .rst_i        (reset),
    .tck_en_i     (tck_en),
    .tms_i        (tms),
    .state_o      (state_cur),
    .state_next_o (state_nxt)
  );

  // Next values of tdo_en, sel_ir and the shift counter, evaluated on TCK strobes.
  always_comb begin
    tdo_en_d    = tdo_en_q;
    sel_ir_d    = sel_ir_q;
    shift_cnt_d = shift_cnt_q;
    if (tck_en) begin
      // Looking at the next state makes tdo_en rise the cycle after entry
      // and drop on the exit edge.
      tdo_en_d = is_shift(state_nxt);

      if (state_nxt == SELIR) begin
        sel_ir_d = 1'b1;
      end else if ((state_nxt == SELDR) || (state_nxt == TLR)) begin
        sel_ir_d = 1'b0;
      end else begin
        sel_ir_d = sel_ir_q;
      end

      // Count restarts at capture; Pause/Exit states leave it untouched so
      // a resumed shift keeps counting.
      if ((state_nxt == CAPIR) || (state_nxt == CAPDR)) begin
        shift_cnt_d = '0;
      end else if (is_shift(state_cur) && (shift_cnt_q != {CNT_W{1'b1}})) begin
        shift_cnt_d = shift_cnt_q + CNT_W'(1);
      end else begin
        shift_cnt_d = shift_cnt_q;
      end
    end else begin
      tdo_en_d    = tdo_en_q;
      sel_ir_d    = sel_ir_q;
      shift_cnt_d = shift_cnt_q;
    end
  end

  // Registered level outputs and shift counter.
  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      tdo_en_q    <= 1'b0;
      sel_ir_q    <= 1'b0;
      shift_cnt_q <= '0;
    end else begin
      tdo_en_q    <= tdo_en_d;
      sel_ir_q    <= sel_ir_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  // Strobes are qualified by tck_en so the cell acts on the same edge that
  // leaves the state; the states are disjoint so at most one fires at a time.
  // Reset forces TLR, which keeps every strobe low during reset.
  assign state     = state_cur;
  assign shift_ir  = (state_cur == SHIR);
  assign shift_dr  = (state_cur == SHDR);
  assign clk_ir    = tck_en & ((state_cur == CAPIR) | (state_cur == SHIR));
  assign clk_dr    = tck_en & ((state_cur == CAPDR) | (state_cur == SHDR));
  assign update_ir = tck_en & (state_cur == UPIR);
  assign update_dr = tck_en & (state_cur == UPDR);
  assign ir_resetn = (state_cur != TLR);
  assign tdo_en    = tdo_en_q;
  assign sel_ir    = sel_ir_q;
  assign shift_cnt = shift_cnt_q;

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// tb_dp_tap_ctrl: table-driven bench for dp_tap_ctrl with a reference model
// and a scoreboard queue of expected post-edge register values.
module tb_dp_tap_ctrl;
  import dp_tap_pkg::*;

  localparam int CW = 8;

  logic          iclk = 1'b0;
  logic          reset = 1'b1;
  logic          tck_en = 1'b0;
  logic          tms = 1'b0;
  logic [3:0]    state;
  logic          shift_ir, clk_ir, update_ir, shift_dr, clk_dr, update_dr;
  logic          ir_resetn, tdo_en, sel_ir;
  logic [CW-1:0] shift_cnt;

  dp_tap_ctrl #(.CNT_W(CW)) dut (
    .iclk      (iclk),
    .reset     (reset),
    .tck_en    (tck_en),
    .tms       (tms),
    .state     (state),
    .shift_ir  (shift_ir),
    .clk_ir    (clk_ir),
    .update_ir (update_ir),
    .shift_dr  (shift_dr),
    .clk_dr    (clk_dr),
    .update_dr (update_dr),
    .ir_resetn (ir_resetn),
    .tdo_en    (tdo_en),
    .sel_ir    (sel_ir),
    .shift_cnt (shift_cnt)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic       en;
    logic       t;
    logic [3:0] st;
    int         tag;
  } vec_t;

  typedef struct {
    logic [3:0]    st;
    logic [4:0]    lv;
    logic [CW-1:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   upd_ir_seen = 0;
  int   upd_dr_seen = 0;

  // Reference transition tables indexed by state code.
  logic [3:0] nxt0 [TAP_STATES];
  logic [3:0] nxt1 [TAP_STATES];

  logic [3:0]    m_st;
  logic          m_tdo;
  logic          m_sel;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_levels();
    return {m_st == 4'hA, m_st == 4'h2, m_st != 4'hF, m_tdo, m_sel};
  endfunction

  task automatic model_reset();
    m_st  = 4'hF;
    m_tdo = 1'b0;
    m_sel = 1'b0;
    m_cnt = '0;
  endtask

  task automatic model_step(input logic en, input logic t);
    logic [3:0] ns;
    if (!en) return;
    ns = t ? nxt1[m_st] : nxt0[m_st];
    if (ns == 4'hE || ns == 4'h6) m_cnt = '0;
    else if ((m_st == 4'hA || m_st == 4'h2) && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 8'd1;
    m_tdo = (ns == 4'hA || ns == 4'h2);
    if (ns == 4'h4) m_sel = 1'b1;
    else if (ns == 4'h7 || ns == 4'hF) m_sel = 1'b0;
    m_st = ns;
  endtask

  // One iclk cycle: drive at negedge, check strobes before the edge,
  // check registered state after the edge against the scoreboard.
  task automatic step(input logic en, input logic t);
    exp_t       e;
    logic [3:0] exp_strb;
    logic [3:0] got_strb;
    @(negedge iclk);
    tck_en = en;
    tms    = t;
    #1;
    exp_strb = {en && (m_st == 4'hE || m_st == 4'hA), en && (m_st == 4'h6 || m_st == 4'h2),
                en && (m_st == 4'hD), en && (m_st == 4'h5)};
    got_strb = {clk_ir, clk_dr, update_ir, update_dr};
    chk("strobes", 32'(got_strb), 32'(exp_strb));
    chk("strobe_onehot", 32'($countones(got_strb) <= 1), 32'd1);
    if (update_ir) upd_ir_seen++;
    if (update_dr) upd_dr_seen++;
    model_step(en, t);
    e.st  = m_st;
    e.lv  = m_levels();
    e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge iclk);
    #1;
    e = sb_q.pop_front();
    chk("state", 32'(state), 32'(e.st));
    chk("levels", 32'({shift_ir, shift_dr, ir_resetn, tdo_en, sel_ir}), 32'(e.lv));
    chk("shift_cnt", 32'(shift_cnt), 32'(e.cnt));
  endtask

  function automatic void add(input logic en, input logic t, input logic [3:0] st, input int tag);
    vec_t v;
    v.en = en; v.t = t; v.st = st; v.tag = tag;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dr_before;
    nxt0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
             4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    nxt1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
             4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    // Five TMS=1 strobes stay in TLR.
    for (int i = 0; i < 5; i++) add(1'b1, 1'b1, 4'hF, 0);
    // 0,1,1,0,0 -> CAPIR then SHIR.
    add(1'b1, 1'b0, 4'hC, 0); add(1'b1, 1'b1, 4'h7, 0); add(1'b1, 1'b1, 4'h4, 0);
    add(1'b1, 1'b0, 4'hE, 0); add(1'b1, 1'b0, 4'hA, 0);
    // IR shift: six more in SHIR, exit via EX1IR to UPIR, then to RTI.
    for (int i = 0; i < 6; i++) add(1'b1, 1'b0, 4'hA, 0);
    add(1'b1, 1'b1, 4'h9, 0); add(1'b1, 1'b1, 4'hD, 0); add(1'b1, 1'b0, 4'hC, 1);
    // DR shift of 4 bits with a pause in the middle.
    add(1'b1, 1'b1, 4'h7, 0); add(1'b1, 1'b0, 4'h6, 0); add(1'b1, 1'b0, 4'h2, 0);
    add(1'b1, 1'b0, 4'h2, 0); add(1'b1, 1'b1, 4'h1, 0); add(1'b1, 1'b0, 4'h3, 0);
    add(1'b1, 1'b0, 4'h3, 5); add(1'b1, 1'b0, 4'h3, 0); add(1'b1, 1'b1, 4'h0, 0);
    add(1'b1, 1'b0, 4'h2, 0); add(1'b1, 1'b0, 4'h2, 0); add(1'b1, 1'b1, 4'h1, 2);
    add(1'b1, 1'b1, 4'h5, 0); add(1'b1, 1'b0, 4'hC, 3);
    // tck_en idle with TMS toggling.
    for (int i = 0; i < 10; i++) add(1'b0, i[0], 4'hC, 0);
    // Walk back into SHDR for the reset-abort sequence.
    add(1'b1, 1'b1, 4'h7, 0); add(1'b1, 1'b0, 4'h6, 0); add(1'b1, 1'b0, 4'h2, 0);
    add(1'b1, 1'b0, 4'h2, 0);

    model_reset();
    repeat (2) @(posedge iclk);
    #1;
    chk("rst_state", 32'(state), 32'hF);
    chk("rst_levels", 32'({ir_resetn, tdo_en, sel_ir}), 32'd0);
    chk("rst_cnt", 32'(shift_cnt), 32'd0);
    @(negedge iclk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].t);
      chk("table_state", 32'(state), 32'(tbl[i].st));
      case (tbl[i].tag)
        1: begin
          chk("ir_cnt7", 32'(shift_cnt), 32'd7);
          chk("ir_update_once", 32'(upd_ir_seen), 32'd1);
        end
        2: begin
          chk("dr_cnt4", 32'(shift_cnt), 32'd4);
          chk("dr_no_update_in_pause", 32'(upd_dr_seen), 32'd0);
        end
        3: chk("dr_update_once", 32'(upd_dr_seen), 32'd1);
        5: chk("tdo_en_pause", 32'(tdo_en), 32'd0);
        default: ;
      endcase
    end

    // Reset while in SHDR with a strobe present: reset wins, shift abandoned.
    dr_before = upd_dr_seen;
    @(negedge iclk);
    tck_en = 1'b1;
    tms    = 1'b1;
    reset  = 1'b1;
    #1;
    chk("rst_mid_state_async", 32'(state), 32'hF);
    chk("rst_mid_strobes", 32'({clk_ir, clk_dr, update_ir, update_dr}), 32'd0);
    @(posedge iclk);
    #1;
    chk("rst_mid_state", 32'(state), 32'hF);
    chk("rst_mid_cnt", 32'(shift_cnt), 32'd0);
    chk("rst_mid_tdo", 32'(tdo_en), 32'd0);
    @(negedge iclk);
    reset  = 1'b0;
    tck_en = 1'b0;
    model_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("rst_resume_rti", 32'(state), 32'hC);
    chk("rst_no_update_dr", 32'(upd_dr_seen), 32'(dr_before));

    // Counter saturation in SHIR, then five TMS=1 strobes reach TLR.
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
    for (int i = 0; i < 260; i++) step(1'b1, 1'b0);
    chk("cnt_saturate", 32'(shift_cnt), 32'hFF);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    chk("five_tms_tlr", 32'(state), 32'hF);
    chk("sel_ir_tlr", 32'(sel_ir), 32'd0);

    tck_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
